// File: rtl/nn_bbox_overlay.sv
// rtl/nn_bbox_overlay.sv - threshold mask stream, accumulate per-frame bounding box, draw it red next frame
module nn_bbox_overlay #(
    parameter int         X_W        = 12,
    parameter int         Y_W        = 12,
    parameter int         CNT_W      = 20,
    parameter logic [7:0] THRESH     = 8'd128,
    parameter int         MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             overlay_en,
    input  logic             vs_in,
    input  logic             hs_in,
    input  logic             de_in,
    input  logic [7:0]       r_in,
    input  logic [7:0]       g_in,
    input  logic [7:0]       b_in,
    output logic             vs_out,
    output logic             hs_out,
    output logic             de_out,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    output logic             box_valid,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [X_W-1:0]   X_MAX   = '1;
    localparam logic [Y_W-1:0]   Y_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             vs1, hs1, de1, en1, hit1, vs_rise1;
    logic [7:0]       r1, g1, b1;
    logic [X_W-1:0]   x_cnt, x1;
    logic [Y_W-1:0]   y_cnt, y1;

    logic [X_W-1:0]   acc_min_x, acc_max_x, box_min_x, box_max_x;
    logic [Y_W-1:0]   acc_min_y, acc_max_y, box_min_y, box_max_y;
    logic [CNT_W-1:0] acc_cnt;

    logic             in_x, in_y, on_edge;

    // x_cnt/y_cnt hold the coordinate of the pixel currently on the inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs1      <= 1'b0;
            hs1      <= 1'b0;
            de1      <= 1'b0;
            en1      <= 1'b0;
            hit1     <= 1'b0;
            vs_rise1 <= 1'b0;
            r1       <= '0;
            g1       <= '0;
            b1       <= '0;
            x1       <= '0;
            y1       <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
        end else begin
            vs1      <= vs_in;
            hs1      <= hs_in;
            de1      <= de_in;
            en1      <= overlay_en;
            hit1     <= de_in && (r_in >= THRESH);
            vs_rise1 <= vs_in && !vs1;
            r1       <= r_in;
            g1       <= g_in;
            b1       <= b_in;
            x1       <= x_cnt;
            y1       <= y_cnt;
            if (!de_in)
                x_cnt <= '0;
            else if (x_cnt != X_MAX)
                x_cnt <= x_cnt + X_W'(1);
            // A coincident de fall loses to the frame start.
            if (vs_in && !vs1)
                y_cnt <= '0;
            else if (de1 && !de_in && y_cnt != Y_MAX)
                y_cnt <= y_cnt + Y_W'(1);
        end
    end

    // The pixel registered alongside the vs rise belongs to neither frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_min_x <= '1;
            acc_min_y <= '1;
            acc_max_x <= '0;
            acc_max_y <= '0;
            acc_cnt   <= '0;
            box_min_x <= '0;
            box_min_y <= '0;
            box_max_x <= '0;
            box_max_y <= '0;
            box_valid <= 1'b0;
            hit_count <= '0;
        end else if (vs_rise1) begin
            box_min_x <= acc_min_x;
            box_min_y <= acc_min_y;
            box_max_x <= acc_max_x;
            box_max_y <= acc_max_y;
            box_valid <= acc_cnt >= CNT_W'(MIN_PIXELS);
            hit_count <= acc_cnt;
            acc_min_x <= '1;
            acc_min_y <= '1;
            acc_max_x <= '0;
            acc_max_y <= '0;
            acc_cnt   <= '0;
        end else if (hit1) begin
            if (x1 < acc_min_x) acc_min_x <= x1;
            if (y1 < acc_min_y) acc_min_y <= y1;
            if (x1 > acc_max_x) acc_max_x <= x1;
            if (y1 > acc_max_y) acc_max_y <= y1;
            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        in_x    = (x1 >= box_min_x) && (x1 <= box_max_x);
        in_y    = (y1 >= box_min_y) && (y1 <= box_max_y);
        on_edge = box_valid && en1 && de1 &&
                  ((((x1 == box_min_x) || (x1 == box_max_x)) && in_y) ||
                   (((y1 == box_min_y) || (y1 == box_max_y)) && in_x));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_out <= 1'b0;
            hs_out <= 1'b0;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            vs_out <= vs1;
            hs_out <= hs1;
            de_out <= de1;
            if (on_edge) begin
                r_out <= 8'hFF;
                g_out <= 8'h00;
                b_out <= 8'h00;
            end else if (de1) begin
                r_out <= r1;
                g_out <= g1;
                b_out <= b1;
            end else begin
                r_out <= '0;
                g_out <= '0;
                b_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nn_bbox_overlay.sv
// tb/tb_nn_bbox_overlay.sv - scoreboard bench for nn_bbox_overlay (MIN_PIXELS 16 and 1 side by side)
module tb_nn_bbox_overlay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, overlay_en, vs_in, hs_in, de_in;
    logic [7:0] r_in, g_in, b_in;

    logic        vs_o0, hs_o0, de_o0, box_valid0;
    logic [7:0]  r_o0, g_o0, b_o0;
    logic [19:0] hit_count0;
    logic        vs_o1, hs_o1, de_o1, box_valid1;
    logic [7:0]  r_o1, g_o1, b_o1;
    logic [19:0] hit_count1;

    nn_bbox_overlay #(.MIN_PIXELS(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .overlay_en(overlay_en),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vs_out(vs_o0), .hs_out(hs_o0), .de_out(de_o0),
        .r_out(r_o0), .g_out(g_o0), .b_out(b_o0),
        .box_valid(box_valid0), .hit_count(hit_count0)
    );

    nn_bbox_overlay #(.MIN_PIXELS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .overlay_en(overlay_en),
        .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vs_out(vs_o1), .hs_out(hs_o1), .de_out(de_o1),
        .r_out(r_o1), .g_out(g_o1), .b_out(b_o1),
        .box_valid(box_valid1), .hit_count(hit_count1)
    );

    wire [47:0] act0 = {vs_o0, hs_o0, de_o0, r_o0, g_o0, b_o0, box_valid0, hit_count0};
    wire [47:0] act1 = {vs_o1, hs_o1, de_o1, r_o1, g_o1, b_o1, box_valid1, hit_count1};

    typedef struct {
        int          stamp;
        logic [47:0] e0;
        logic [47:0] e1;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        st_bv0, st_bv1;
    logic [19:0] st_hc0, st_hc1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].stamp < cyc) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            $display("FAIL missed_output: entry for cycle %0d unchecked at cycle %0d", mon_e.stamp, cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].stamp == cyc) begin
            mon_e = sb_q.pop_front();
            check("dut0_out", act0, mon_e.e0);
            check("dut1_out", act1, mon_e.e1);
        end
    end

    function automatic logic on_box(input int x, input int y, input int x0, input int y0,
                                    input int x1, input int y1);
        return ((x == x0 || x == x1) && y >= y0 && y <= y1) ||
               ((y == y0 || y == y1) && x >= x0 && x <= x1);
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic ov, input logic [23:0] rgb0, input logic [23:0] rgb1);
        exp_t e;
        @(posedge clk);
        #1;
        vs_in = vs; hs_in = hs; de_in = de;
        r_in = r; g_in = g; b_in = b;
        overlay_en = ov;
        e.stamp = cyc + 2;
        e.e0 = {vs, hs, de, rgb0, st_bv0, st_hc0};
        e.e1 = {vs, hs, de, rgb1, st_bv1, st_hc1};
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b1, 24'h0, 24'h0);
    endtask

    // One frame: vs line, 8 lines of 4 blank + 16 active pixels, trailing blank line.
    // n* is the status expected once the previous frame closes; d* is the box drawn now.
    task automatic run_frame(input int hx0, input int hy0, input int hx1, input int hy1,
                             input int nlim, input int rall, input logic ov,
                             input int dx0, input int dy0, input int dx1, input int dy1,
                             input logic dv0, input logic dv1, input logic inj, input int yoff,
                             input logic nbv0, input int nhc0, input logic nbv1, input int nhc1,
                             input int rst_at);
        int          rank;
        int          c;
        int          x;
        logic        hit, red;
        logic [7:0]  r, g, b;
        logic [23:0] px;
        rank = 0;
        c = 0;
        st_bv0 = nbv0; st_hc0 = 20'(nhc0);
        st_bv1 = nbv1; st_hc1 = 20'(nhc1);
        for (int i = 0; i < 20; i++) begin
            if (inj && i == 0)
                drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 8'h02, 1'b0, 24'hFF0102, 24'hFF0102);
            else
                drive(i < 4, i < 2, 1'b0, 8'h11, 8'h22, 8'h33, ov, 24'h0, 24'h0);
            c++;
        end
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 20; i++) begin
                if (c == rst_at) begin
                    @(posedge clk);
                    #1;
                    reset_n = 1'b0;
                    #1;
                    check("async_reset_dut0", act0, 48'h0);
                    check("async_reset_dut1", act1, 48'h0);
                    sb_q.delete();
                    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
                    return;
                end
                if (i < 4) begin
                    drive(1'b0, i < 2, 1'b0, 8'h11, 8'h22, 8'h33, ov, 24'h0, 24'h0);
                end else begin
                    x = i - 4;
                    hit = 1'b0;
                    if (x >= hx0 && x <= hx1 && l >= hy0 && l <= hy1) begin
                        hit = (rank < nlim);
                        rank++;
                    end
                    r = (rall >= 0) ? 8'(rall) : (hit ? 8'd200 : 8'd0);
                    g = 8'(x * 16 + l);
                    b = 8'((x * 7 + l * 13) ^ 60);
                    px = {r, g, b};
                    red = ov && on_box(x, l + yoff, dx0, dy0, dx1, dy1);
                    drive(1'b0, 1'b0, 1'b1, r, g, b, ov,
                          (red && dv0) ? 24'hFF0000 : px, (red && dv1) ? 24'hFF0000 : px);
                end
                c++;
            end
        end
        for (int i = 0; i < 20; i++)
            drive(1'b0, i < 2, 1'b0, 8'h11, 8'h22, 8'h33, ov, 24'h0, 24'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        overlay_en = 1'b1;
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
        r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
        st_bv0 = 1'b0; st_bv1 = 1'b0; st_hc0 = '0; st_hc1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_dut0", act0, 48'h0);
        check("reset_state_dut1", act1, 48'h0);
        reset_n = 1'b1;
        idle(10);
        // 32-hit rectangle, nothing drawn yet
        run_frame(3, 2, 10, 5, 32, -1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, -1);
        // 15 hits; draws the 32-hit box
        run_frame(3, 2, 10, 5, 15, -1, 1'b1, 3, 2, 10, 5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32, 1'b1, 32, -1);
        // r=127 everywhere; 15-hit box only valid for MIN_PIXELS=1
        run_frame(0, 0, 0, 0, 0, 127, 1'b1, 3, 2, 10, 3, 1'b0, 1'b1, 1'b0, 0, 1'b0, 15, 1'b1, 15, -1);
        // r=128 everywhere
        run_frame(0, 0, 0, 0, 0, 128, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, -1);
        // full-frame box from the 128-hit frame
        run_frame(3, 2, 10, 5, 32, -1, 1'b1, 0, 0, 15, 7, 1'b1, 1'b1, 1'b0, 0, 1'b1, 128, 1'b1, 128, -1);
        // overlay disabled with a valid box
        run_frame(3, 2, 10, 5, 32, -1, 1'b0, 3, 2, 10, 5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32, 1'b1, 32, -1);
        // single hit at (7,4)
        run_frame(7, 4, 7, 4, 1, -1, 1'b1, 3, 2, 10, 5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32, 1'b1, 32, -1);
        // hit injected with the vs rise; its de fall shifts rows by one
        run_frame(0, 0, 0, 0, 0, -1, 1'b1, 7, 4, 7, 4, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1, 1'b1, 1, -1);
        // reset asserted mid-line while de is high
        run_frame(0, 0, 9, 1, 20, -1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 49);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        st_bv0 = 1'b0; st_bv1 = 1'b0; st_hc0 = '0; st_hc1 = '0;
        idle(8);
        run_frame(0, 0, 9, 1, 20, -1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, -1);
        run_frame(0, 0, 0, 0, 0, -1, 1'b1, 0, 0, 9, 1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 20, 1'b1, 20, -1);
        run_frame(0, 0, 0, 0, 0, -1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, -1);
        idle(6);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0)
            n_pass++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nn_bbox_overlay.md
# nn_bbox_overlay

Downstream stage of the RGB neural-network classifier. Consumes the classifier's grayscale mask stream and its delayed vs/hs/de, and thresholds each pixel. It accumulates the per-frame bounding box and hit count of mask pixels. During the following frame it draws that box as a 1-pixel red rectangle over the mask video. All other video passes through with fixed latency.

## Interface
Parameters:
- X_W, 12, column counter width
- Y_W, 12, row counter width
- CNT_W, 20, hit counter width (saturating)
- THRESH, 8'd128, mask pixel is a hit when r_in >= THRESH
- MIN_PIXELS, 16, minimum hits for a valid box

Ports:
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  reset; asynchronous, active-low
- overlay_en  in  1  1 = draw box, 0 = pure pass-through
- vs_in / hs_in / de_in  in  1 each  syncs from classifier; vs active-high
- r_in / g_in / b_in  in  8 each  mask pixel; only r_in is thresholded
- vs_out / hs_out / de_out  out  1 each  syncs delayed 2 cycles
- r_out / g_out / b_out  out  8 each  video out
- box_valid  out  1  last closed frame produced a valid box
- hit_count  out  CNT_W  hit count of last closed frame

## Operation
- Stage 1 registers all inputs and computes hit = de_in & (r_in >= THRESH). It also registers the current coordinates (x, y).
- x counts active pixels from 0 within a line and resets to 0 on the cycle after de falls. It saturates at 2^X_W-1.
- y increments on each de falling edge and resets to 0 on the vs rising edge. It saturates at 2^Y_W-1.
- Accumulators: acc_min_x/acc_min_y (empty = all ones), acc_max_x/acc_max_y (empty = 0), acc_cnt.
  - On a hit: min/max update and acc_cnt increments.
  - acc_cnt saturates at 2^CNT_W-1.
- Frame close on the vs_in rising edge:
  - box_* registers take the accumulator values.
  - box_valid = (acc_cnt >= MIN_PIXELS).
  - hit_count = acc_cnt.
  - Accumulators return to empty in the same cycle.
  - A hit arriving in the vs rising-edge cycle is excluded from both frames. It is still output as video.
- Stage 2 computes edge = box_valid & overlay_en & de.
  - edge is true when ((x == box_min_x | x == box_max_x) & box_min_y <= y <= box_max_y) | ((y == box_min_y | y == box_max_y) & box_min_x <= x <= box_max_x).
- Output selection:
  - edge: rgb = FF/00/00.
  - de & !edge: rgb = input pixel unchanged.
  - !de: rgb = 0.
- The box drawn in frame N always comes from frame N-1. A box never updates mid-frame.
- overlay_en is sampled per pixel at stage 1. Toggling it mid-frame affects only subsequent pixels.
- Single-pixel box (min == max): draws one red pixel.

## Timing
- Latency is exactly 2 cycles from any input to the corresponding output, for syncs and pixel data alike.
- box_valid and hit_count update 1 cycle after the cycle in which the vs_in rising edge is registered. They are stable for the whole following frame.
- No back-pressure. One pixel per clock. de may deassert at any cycle.
- Reset (asynchronous assert, any time including mid-frame):
  - All outputs are 0, including syncs, rgb, box_valid and hit_count.
  - x = y = 0 and accumulators are empty.
  - After deassertion, the first vs rising edge closes a partial frame normally.
- Back-to-back frames with no blanking between the last de and vs are supported. The final de falling edge and the vs edge may coincide; y reset wins.

## Test plan
- 16x8 active frame, blanking 4 px/2 lines; hits at (3..10, 2..5) (32 px), THRESH 128, r_in = 200 on hits and 0 elsewhere → after vs: box_valid = 1, hit_count = 32. Next frame: red at x = 3 or 10 for y in 2..5, and at y = 2 or 5 for x in 3..10. All other de pixels equal the input. Latency 2 on all signals.
- Same frame with only 15 hits → box_valid = 0, hit_count = 15; the next frame has no red pixels.
- r_in = 127 everywhere versus 128 everywhere → hit_count 0 versus 128.
- overlay_en = 0 with a valid box → output identical to input delayed 2 cycles; box_valid is still 1.
- Assert reset_n = 0 mid-frame during de → all outputs 0 asynchronously. After release and one full frame of 20 hits, box_valid = 1 and hit_count = 20.
- Single hit pixel at (7,4) with MIN_PIXELS = 1 → next frame has exactly one red pixel at (7,4). A hit injected in the vs rising-edge cycle changes neither hit_count nor the box.
